// File: rtl/frame_mapping_lookup_pkg.sv
// Shared definitions for the DMAC -> TSN flow ID lookup: entry layout, widths, FSM encoding and hash.
package frame_mapping_lookup_pkg;

  localparam int ENTRY_W    = 64;
  localparam int VALID_BIT  = 63;
  localparam int DMAC_MSB   = 62;
  localparam int DMAC_LSB   = 15;
  localparam int FLOWID_MSB = 14;
  localparam int FLOWID_LSB = 1;

  localparam int DMAC_W     = 48;
  localparam int BUFID_W    = 9;
  localparam int FLOWID_W   = 14;
  localparam int DESC_W     = DMAC_W + BUFID_W;
  localparam int MISS_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_CMP  = 3'd3,
    ST_OUT  = 3'd4
  } fml_state_e;

  // Byte-wise XOR fold of the DMAC; callers truncate to the table address width.
  function automatic logic [7:0] dmac_hash(input logic [DMAC_W-1:0] dmac);
    return dmac[7:0] ^ dmac[15:8] ^ dmac[23:16] ^ dmac[31:24] ^ dmac[39:32] ^ dmac[47:40];
  endfunction

endpackage

// File: rtl/frame_mapping_lookup_map_table_ram.sv
// Dual-port mapping table: port A is the CPU config read/write port, port B the read-only lookup port.
module map_table_ram #(
  parameter int AW     = 8,
  parameter int DW     = 64,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_a,
  input  logic          i_rd_a,
  input  logic [AW-1:0] iv_addr_a,
  input  logic [DW-1:0] iv_wdata_a,
  output logic [DW-1:0] ov_rdata_a,
  input  logic          i_rd_b,
  input  logic [AW-1:0] iv_addr_b,
  output logic [DW-1:1] ov_rdata_b
);

  logic [DW-1:0] mem [2**AW];

  logic [DW-1:0] rd_a_q, rd_a_d;
  logic [DW-1:1] rd_b_q, rd_b_d;

  always_ff @(posedge i_clk) begin
    if (i_wr_a) mem[iv_addr_a] <= iv_wdata_a;
  end

  // Reads sample the array before this edge's write lands, so a colliding read sees old data.
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (i_rd_a) rd_a_d = mem[iv_addr_a];
    if (i_rd_b) rd_b_d = mem[iv_addr_b][DW-1:1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] rd_a2_q;
    logic [DW-1:1] rd_b2_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd_a2_q <= '0;
        rd_b2_q <= '0;
      end else begin
        rd_a2_q <= rd_a_q;
        rd_b2_q <= rd_b_q;
      end
    end
    assign ov_rdata_a = rd_a2_q;
    assign ov_rdata_b = rd_b2_q;
  end else begin : g_lat1
    assign ov_rdata_a = rd_a_q;
    assign ov_rdata_b = rd_b_q;
  end

endmodule

// File: rtl/frame_mapping_lookup.sv
// Receive-path DMAC -> TSN flow ID lookup, one descriptor in flight.
// Optional miss counter output ov_miss_cnt is built when MAP_MISS_CNT_EN is defined.
module frame_mapping_lookup
  import frame_mapping_lookup_pkg::*;
#(
  parameter int TABLE_AW   = 8,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef MAP_MISS_CNT_EN
  output logic [MISS_CNT_W-1:0] ov_miss_cnt,
`endif
  input  logic [DESC_W-1:0]     iv_descriptor,
  input  logic                  i_descriptor_wr,
  output logic                  o_descriptor_ready,
  input  logic [ENTRY_W-1:0]    iv_map_ram_wdata,
  input  logic                  i_map_ram_wr,
  input  logic [TABLE_AW-1:0]   iv_map_ram_addr,
  input  logic                  i_map_ram_rd,
  output logic [ENTRY_W-1:0]    ov_map_ram_rdata,
  output logic [FLOWID_W-1:0]   ov_flowid,
  output logic [BUFID_W-1:0]    ov_bufid,
  output logic                  o_lookup_table_match_flag,
  output logic                  o_descriptor_wr,
  input  logic                  i_descriptor_ready,
  output logic [2:0]            ov_dbg_state
);

  localparam logic [1:0] WAIT_LAST = 2'(RAM_RD_LAT - 1);

  fml_state_e            state_q, state_d;
  logic [DMAC_W-1:0]     dmac_q, dmac_d;
  logic [BUFID_W-1:0]    bufid_q, bufid_d;
  logic [TABLE_AW-1:0]   index_q, index_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [FLOWID_W-1:0]   flowid_q, flowid_d;
  logic [BUFID_W-1:0]    obufid_q, obufid_d;
  logic                  match_q, match_d;
  logic                  ready_q, ready_d;

  logic [ENTRY_W-1:1]    entry_b;
  logic                  rden_b;
  logic                  hit;
  logic                  accept;

  map_table_ram #(
    .AW     (TABLE_AW),
    .DW     (ENTRY_W),
    .RD_LAT (RAM_RD_LAT)
  ) u_map_table_ram (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_a     (i_map_ram_wr),
    .i_rd_a     (i_map_ram_rd),
    .iv_addr_a  (iv_map_ram_addr),
    .iv_wdata_a (iv_map_ram_wdata),
    .ov_rdata_a (ov_map_ram_rdata),
    .i_rd_b     (rden_b),
    .iv_addr_b  (index_q),
    .ov_rdata_b (entry_b)
  );

  // Handshakes: a descriptor transfers on a cycle where wr and ready are both 1 (upstream only
  // raises i_descriptor_wr while o_descriptor_ready=1); o_descriptor_wr is raised only when
  // i_descriptor_ready=1, so every o_descriptor_wr pulse is a completed single-cycle transfer.
  assign accept = i_descriptor_wr && ready_q && (state_q == ST_IDLE);
  assign rden_b = (state_q == ST_READ);
  assign hit    = entry_b[VALID_BIT] && (entry_b[DMAC_MSB:DMAC_LSB] == dmac_q);

  always_comb begin
    state_d    = state_q;
    dmac_d     = dmac_q;
    bufid_d    = bufid_q;
    index_d    = index_q;
    wait_cnt_d = wait_cnt_q;
    flowid_d   = flowid_q;
    obufid_d   = obufid_q;
    match_d    = match_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dmac_d  = iv_descriptor[DESC_W-1:BUFID_W];
          bufid_d = iv_descriptor[BUFID_W-1:0];
          index_d = TABLE_AW'(dmac_hash(iv_descriptor[DESC_W-1:BUFID_W]));
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = ST_CMP;
        else                         wait_cnt_d = wait_cnt_q + 2'd1;
      end
      ST_CMP: begin
        flowid_d = hit ? entry_b[FLOWID_MSB:FLOWID_LSB] : '0;
        obufid_d = bufid_q;
        match_d  = hit;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (i_descriptor_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      dmac_q     <= '0;
      bufid_q    <= '0;
      index_q    <= '0;
      wait_cnt_q <= '0;
      flowid_q   <= '0;
      obufid_q   <= '0;
      match_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dmac_q     <= dmac_d;
      bufid_q    <= bufid_d;
      index_q    <= index_d;
      wait_cnt_q <= wait_cnt_d;
      flowid_q   <= flowid_d;
      obufid_q   <= obufid_d;
      match_q    <= match_d;
      ready_q    <= ready_d;
    end
  end

`ifdef MAP_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Only reset clears the counter; table writes never touch it.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_CMP && !hit && miss_cnt_q != {MISS_CNT_W{1'b1}})
      miss_cnt_d = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) miss_cnt_q <= '0;
    else       miss_cnt_q <= miss_cnt_d;
  end

  assign ov_miss_cnt = miss_cnt_q;
`endif

  assign o_descriptor_ready        = ready_q;
  assign o_descriptor_wr           = (state_q == ST_OUT) && i_descriptor_ready;
  assign ov_flowid                 = flowid_q;
  assign ov_bufid                  = obufid_q;
  assign o_lookup_table_match_flag = match_q;
  assign ov_dbg_state              = state_q;

endmodule
